// File: rtl/svc_uart_tx_arb_if.sv
// Byte-stream bus between the requesters, the shared UART TX byte port and the
// line-atomic arbiter that sits in between.
interface svc_uart_tx_arb_if #(
    parameter int NUM_REQ = 2
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic [OW-1:0]        owner;
    logic                 locked;

    // master: requesters plus UART side; slave: the arbiter
    modport master (
        output req_valid, req_data, tx_ready,
        input  req_ready, tx_valid, tx_data, owner, locked
    );

    modport slave (
        input  req_valid, req_data, tx_ready,
        output req_ready, tx_valid, tx_data, owner, locked
    );
endinterface

// File: rtl/svc_uart_tx_arb.sv
// Line-atomic round-robin arbiter sharing one UART TX byte port; the owner keeps
// the transmitter until it sends EOL_BYTE or sits idle for LOCK_TIMEOUT cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no owner; pick first valid requester upward from rr_ptr
// ST_LOCKED | owner streams bytes into the output register until EOL/timeout
module svc_uart_tx_arb #(
    parameter int         NUM_REQ      = 2,
    parameter logic [7:0] EOL_BYTE     = 8'h0A,
    parameter int         LOCK_TIMEOUT = 1024
) (
    input logic                clk,
    input logic                rst_n,
    svc_uart_tx_arb_if.slave   bus
);
    localparam int PW  = $clog2(NUM_REQ);
    localparam int PW1 = PW + 1;
    localparam int CW  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic          locked_w;
    logic          own_valid;
    logic [7:0]    own_data;
    logic          tx_free;
    logic          accept;
    logic [PW-1:0] owner_inc;
    logic          sel_found;
    logic [PW-1:0] sel_idx;
    logic [PW:0]   cand;
    logic [NUM_REQ-1:0] req_ready_w;

    assign locked_w  = (state_q == ST_LOCKED);
    assign own_valid = bus.req_valid[owner_q];
    assign own_data  = bus.req_data[{owner_q, 3'b000} +: 8];
    assign tx_free   = !tx_valid_q || bus.tx_ready;
    assign accept    = locked_w && own_valid && tx_free;
    assign owner_inc = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

    // Walk offsets from high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + PW1'(i);
            if (cand >= PW1'(NUM_REQ)) begin
                cand = cand - PW1'(NUM_REQ);
            end
            if (bus.req_valid[cand[PW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data;
        end else if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sel_found) begin
                    owner_d = sel_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept && (own_data == EOL_BYTE)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_inc;
                    cnt_d    = '0;
                end else if (own_valid) begin
                    // backpressured owner is still active, not idle
                    cnt_d = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_inc;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        req_ready_w = '0;
        if (locked_w) begin
            req_ready_w[owner_q] = tx_free;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.owner     = owner_q;
    assign bus.locked    = locked_w;
endmodule

// File: tb/tb_svc_uart_tx_arb.sv
// Directed bench for svc_uart_tx_arb: two requesters fed from byte queues,
// outputs compared against hand-derived cycle-by-cycle expectations.
module tb_svc_uart_tx_arb;
    localparam int NUM_REQ = 2;
    localparam int TMO     = 16;

    logic clk;
    logic rst_n;

    svc_uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    svc_uart_tx_arb #(
        .NUM_REQ(NUM_REQ),
        .EOL_BYTE(8'h0A),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] txlog[$];
    logic [7:0] grants[$];
    logic [1:0] acc = '0;
    logic [7:0] junk;
    logic       prev;

    logic [7:0] exp2 [6] = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h44, 8'h0A};
    logic [7:0] exp3 [4] = '{8'h00, 8'h01, 8'h00, 8'h01};
    logic [7:0] exp6 [3] = '{8'h32, 8'h0A, 8'h0A};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Accepts and UART pops are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            acc = bus.req_valid & bus.req_ready;
            if (bus.tx_valid && bus.tx_ready) txlog.push_back(bus.tx_data);
        end else begin
            acc = '0;
        end
    end

    // Requester model: hold the front byte until accepted, then advance.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (acc[0] && q0.size() > 0) junk = q0.pop_front();
            if (acc[1] && q1.size() > 0) junk = q1.pop_front();
            bus.req_valid = {q1.size() > 0, q0.size() > 0};
            bus.req_data  = {(q1.size() > 0) ? q1[0] : 8'h00,
                             (q0.size() > 0) ? q0[0] : 8'h00};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.tx_ready = 1'b0;
        #2;
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_owner", bus.owner, 0);
        step();
        step();
        rst_n        = 1'b1;
        bus.tx_ready = 1'b1;

        // single line "hi\n" from requester 0
        q0.push_back(8'h68); q0.push_back(8'h69); q0.push_back(8'h0A);
        step();
        check("t1_c0_locked", bus.locked, 0);
        check("t1_c0_ready", bus.req_ready, 0);
        step();
        check("t1_c1_locked", bus.locked, 1);
        check("t1_c1_owner", bus.owner, 0);
        check("t1_c1_ready", bus.req_ready, 2'b01);
        check("t1_c1_txv", bus.tx_valid, 0);
        step();
        check("t1_c2_txv", bus.tx_valid, 1);
        check("t1_c2_data", bus.tx_data, 8'h68);
        step();
        check("t1_c3_data", bus.tx_data, 8'h69);
        step();
        check("t1_c4_data", bus.tx_data, 8'h0A);
        check("t1_c4_locked", bus.locked, 0);
        step();
        check("t1_c5_txv", bus.tx_valid, 0);
        check("t1_c5_owner", bus.owner, 0);

        // two simultaneous lines from reset, no interleave
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        txlog.delete();
        q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h0A);
        q1.push_back(8'h43); q1.push_back(8'h44); q1.push_back(8'h0A);
        step();
        step();
        check("t2_c1_owner", bus.owner, 0);
        check("t2_c1_locked", bus.locked, 1);
        step();
        step();
        step();
        check("t2_c4_locked", bus.locked, 0);
        check("t2_c4_owner", bus.owner, 0);
        step();
        check("t2_c5_locked", bus.locked, 1);
        check("t2_c5_owner", bus.owner, 1);
        check("t2_c5_ready", bus.req_ready, 2'b10);
        repeat (6) step();
        check("t2_count", txlog.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_byte%0d", i), (txlog.size() > i) ? txlog[i] : 8'hFF, exp2[i]);

        // back-to-back one-byte lines: fairness
        txlog.delete();
        grants.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'h0A);
            q1.push_back(8'h0A);
        end
        prev = bus.locked;
        repeat (22) begin
            step();
            if (bus.locked && !prev) grants.push_back({7'd0, bus.owner});
            prev = bus.locked;
        end
        check("t3_grants", grants.size(), 8);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_grant%0d", i), (grants.size() > i) ? grants[i] : 8'hFF, exp3[i]);
        check("t3_bytes", txlog.size(), 8);

        // stalled owner released by idle timeout
        q0.push_back(8'h58);
        step();
        step();
        check("t4_c1_locked", bus.locked, 1);
        check("t4_c1_owner", bus.owner, 0);
        repeat (4) step();
        q1.push_back(8'h0A);
        repeat (12) step();
        check("t4_c17_locked", bus.locked, 1);
        check("t4_c17_ready", bus.req_ready, 2'b01);
        step();
        check("t4_c18_locked", bus.locked, 0);
        check("t4_c18_owner", bus.owner, 0);
        check("t4_c18_ready", bus.req_ready, 0);
        step();
        check("t4_c19_locked", bus.locked, 1);
        check("t4_c19_owner", bus.owner, 1);
        step();
        step();

        // output backpressure holds the byte and does not count as idle
        bus.tx_ready = 1'b0;
        q0.push_back(8'h5A); q0.push_back(8'h0A);
        step();
        step();
        check("t5_c1_ready", bus.req_ready, 2'b01);
        check("t5_c1_owner", bus.owner, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t5_hold_txv", bus.tx_valid, 1);
            check("t5_hold_data", bus.tx_data, 8'h5A);
            check("t5_hold_ready", bus.req_ready, 0);
            check("t5_hold_locked", bus.locked, 1);
        end
        bus.tx_ready = 1'b1;
        #1;
        check("t5_drain_ready", bus.req_ready, 2'b01);
        step();
        check("t5_next_data", bus.tx_data, 8'h0A);
        check("t5_next_txv", bus.tx_valid, 1);
        check("t5_next_locked", bus.locked, 0);
        step();
        check("t5_empty_txv", bus.tx_valid, 0);

        // asynchronous reset mid-line
        q0.push_back(8'h31); q0.push_back(8'h32); q0.push_back(8'h0A);
        step();
        step();
        check("t6_c1_owner", bus.owner, 0);
        check("t6_c1_locked", bus.locked, 1);
        step();
        check("t6_c2_txv", bus.tx_valid, 1);
        check("t6_c2_data", bus.tx_data, 8'h31);
        rst_n = 1'b0;
        txlog.delete();
        q1.push_back(8'h0A);
        #1;
        check("t6_rst_txv", bus.tx_valid, 0);
        check("t6_rst_data", bus.tx_data, 8'h00);
        check("t6_rst_locked", bus.locked, 0);
        check("t6_rst_ready", bus.req_ready, 0);
        check("t6_rst_owner", bus.owner, 0);
        step();
        rst_n = 1'b1;
        check("t6_d0_locked", bus.locked, 0);
        step();
        check("t6_d1_locked", bus.locked, 1);
        check("t6_d1_owner", bus.owner, 0);
        repeat (6) step();
        check("t6_count", txlog.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t6_byte%0d", i), (txlog.size() > i) ? txlog[i] : 8'hFF, exp6[i]);
        check("t6_final_owner", bus.owner, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
